runner_input: RTL and testbench

PS/2 keyboard front end that produces the `jumping` and `ducking` levels consumed by the runner game logic.
- Receives raw ps2_clk/ps2_data from the board and filters and deserialises 11-bit frames.
- Decodes set-2 make/break scancodes and keeps per-key pressed state.
- Sits between the board I/O pins and runner; runs entirely in the system clock domain.

---
 rtl/runner_input.sv | 213 +++++++++++++++++++++
 tb/tb_runner_input.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/runner_input.sv
// PS/2 keyboard front end: sync + glitch filter, 11-bit frame receiver and set-2 decoder
// producing jumping/ducking levels. Optional macro RUNNER_INPUT_SCANCODE_OUT_EN adds scancode outputs.
module runner_input #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       jumping,
  output logic       ducking,
  output logic       frame_err
`ifdef RUNNER_INPUT_SCANCODE_OUT_EN
  ,
  output logic [7:0] scancode,
  output logic       scancode_valid
`endif
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam int unsigned K_SPACE = 0;
  localparam int unsigned K_UP    = 1;
  localparam int unsigned K_W     = 2;
  localparam int unsigned K_DOWN  = 3;
  localparam int unsigned K_S     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic          r_clk_s1;
  logic          r_clk_s2;
  logic          r_dat_s1;
  logic          r_dat_s2;
  logic          r_clk_f;
  logic          r_clk_f_d;
  logic [FW-1:0] r_flt_cnt;
  logic          w_fall;

  state_t        r_state;
  state_t        r_state_nxt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shreg;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          r_byte_strobe;
  logic          r_frame_err;

  logic          w_timeout;
  logic          w_shift;
  logic          w_par_ld;
  logic          w_strobe;
  logic          w_bad;

  logic          r_ext;
  logic          r_brk;
  logic [4:0]    r_keys;
  logic          w_key_hit;
  logic [2:0]    w_key_idx;

  // Input synchronisers and clock glitch filter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_clk_f   <= 1'b1;
      r_clk_f_d <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_clk_s1  <= ps2_clk;
      r_clk_s2  <= r_clk_s1;
      r_dat_s1  <= ps2_data;
      r_dat_s2  <= r_dat_s1;
      r_clk_f_d <= r_clk_f;
      if (r_clk_s2 != r_clk_f) begin
        if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
          r_clk_f   <= r_clk_s2;
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + FW'(1);
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  assign w_fall    = r_clk_f_d & ~r_clk_f;
  assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Receiver next-state; timeout has priority over a coincident fall
  always_comb begin
    r_state_nxt = r_state;
    w_shift     = 1'b0;
    w_par_ld    = 1'b0;
    w_strobe    = 1'b0;
    w_bad       = 1'b0;
    if (w_timeout) begin
      r_state_nxt = ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) r_state_nxt = ST_DATA;
        end
        ST_DATA: begin
          w_shift = 1'b1;
          if (r_bit_cnt == 3'd7) r_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_ld    = 1'b1;
          r_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          r_state_nxt = ST_IDLE;
          if (r_dat_s2 && ((^r_shreg) ^ r_parity)) w_strobe = 1'b1;
          else                                      w_bad    = 1'b1;
        end
        default: r_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_shreg       <= '0;
      r_parity      <= 1'b0;
      r_to_cnt      <= '0;
      r_byte_strobe <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= r_state_nxt;
      r_byte_strobe <= w_strobe;
      r_frame_err   <= w_bad | w_timeout;
      if (r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_shreg   <= {r_dat_s2, r_shreg[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_par_ld) r_parity <= r_dat_s2;
      if (r_state == ST_IDLE || w_timeout || w_fall) r_to_cnt <= '0;
      else                                           r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // Key map lookup on the (ext, code) pair
  always_comb begin
    w_key_hit = 1'b0;
    w_key_idx = '0;
    case ({r_ext, r_shreg})
      9'h029: begin w_key_hit = 1'b1; w_key_idx = 3'(K_SPACE); end
      9'h175: begin w_key_hit = 1'b1; w_key_idx = 3'(K_UP);    end
      9'h01D: begin w_key_hit = 1'b1; w_key_idx = 3'(K_W);     end
      9'h172: begin w_key_hit = 1'b1; w_key_idx = 3'(K_DOWN);  end
      9'h01B: begin w_key_hit = 1'b1; w_key_idx = 3'(K_S);     end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_keys <= '0;
    end else if (w_bad) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_byte_strobe) begin
      case (r_shreg)
        8'hE0: r_ext <= 1'b1;
        8'hF0: r_brk <= 1'b1;
        8'hAA: begin
          r_keys <= '0;
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end
        default: begin
          if (w_key_hit) r_keys[w_key_idx] <= ~r_brk;
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      endcase
    end
  end

  assign jumping   = r_keys[K_SPACE] | r_keys[K_UP] | r_keys[K_W];
  assign ducking   = r_keys[K_DOWN] | r_keys[K_S];
  assign frame_err = r_frame_err;

`ifdef RUNNER_INPUT_SCANCODE_OUT_EN
  logic [7:0] r_scancode;

  // Loaded with the strobe so scancode is already valid while scancode_valid is high
  always_ff @(posedge clk) begin
    if (rst)           r_scancode <= '0;
    else if (w_strobe) r_scancode <= r_shreg;
  end

  assign scancode       = r_scancode;
  assign scancode_valid = r_byte_strobe;
`endif

endmodule

// File: tb/tb_runner_input.sv
// Directed self-checking bench for runner_input; uses a short timeout so the
// timeout scenario stays within a small cycle budget.
module tb_runner_input;

  localparam int unsigned TO = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic jumping;
  logic ducking;
  logic frame_err;
`ifdef RUNNER_INPUT_SCANCODE_OUT_EN
  logic [7:0] scancode;
  logic       scancode_valid;
`endif

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int jump_drops = 0;
  logic watch_jump = 1'b0;

  always #5 clk = ~clk;

  runner_input #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .jumping        (jumping),
    .ducking        (ducking),
    .frame_err      (frame_err)
`ifdef RUNNER_INPUT_SCANCODE_OUT_EN
    ,
    .scancode       (scancode),
    .scancode_valid (scancode_valid)
`endif
  );

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_pulses++;
    if (watch_jump && jumping !== 1'b1) jump_drops++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data settles, clock low 20 cycles, high 10 cycles.
  // With lat_chk, jumping must rise exactly on the 12th negedge after the raw
  // fall: 2 sync stages + 8 filter samples, fall cycle, strobe cycle, key update.
  task automatic send_bit(input logic b, input logic lat_chk);
    @(negedge clk);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    if (lat_chk) begin
      repeat (11) @(negedge clk);
      checks++;
      if (jumping !== 1'b0) begin
        errors++;
        $display("FAIL latency_early: jumping=%b required 0", jumping);
      end
      @(negedge clk);
      checks++;
      if (jumping !== 1'b1) begin
        errors++;
        $display("FAIL latency_on_time: jumping=%b required 1", jumping);
      end
      repeat (8) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic lat_chk);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(p, 1'b0);
    send_bit(1'b1, lat_chk);
    idle(5);
  endtask

  task automatic test_reset;
    int e0;
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (jumping !== 1'b0 || ducking !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: j=%b d=%b e=%b required 0 0 0", jumping, ducking, frame_err);
    end
    rst = 1'b0;
    e0 = err_pulses;
    idle(1000);
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL idle_no_err: pulses=%0d required %0d", err_pulses, e0);
    end
    checks++;
    if (jumping !== 1'b0 || ducking !== 1'b0) begin
      errors++;
      $display("FAIL idle_outputs: j=%b d=%b required 0 0", jumping, ducking);
    end
  endtask

  task automatic test_jump_basic;
    int e0;
    e0 = err_pulses;
    send_frame(8'h29, 1'b0, 1'b1);
    checks++;
    if (jumping !== 1'b1 || ducking !== 1'b0) begin
      errors++;
      $display("FAIL space_make: j=%b d=%b required 1 0", jumping, ducking);
    end
    send_frame(8'hF0, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b1) begin
      errors++;
      $display("FAIL brk_prefix_only: jumping=%b required 1", jumping);
    end
    send_frame(8'h29, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b0 || ducking !== 1'b0) begin
      errors++;
      $display("FAIL space_break: j=%b d=%b required 0 0", jumping, ducking);
    end
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL jump_basic_no_err: pulses=%0d required %0d", err_pulses, e0);
    end
  endtask

  task automatic test_multi_jump;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b1) begin
      errors++;
      $display("FAIL up_make: jumping=%b required 1", jumping);
    end
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b1) begin
      errors++;
      $display("FAIL up_break_w_held: jumping=%b required 1", jumping);
    end
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b0 || ducking !== 1'b0) begin
      errors++;
      $display("FAIL w_break: j=%b d=%b required 0 0", jumping, ducking);
    end
  endtask

  task automatic test_typematic;
    send_frame(8'h29, 1'b0, 1'b0);
    jump_drops = 0;
    watch_jump = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(8'h29, 1'b0, 1'b0);
    watch_jump = 1'b0;
    checks++;
    if (jump_drops !== 0 || jumping !== 1'b1) begin
      errors++;
      $display("FAIL typematic: drops=%0d jumping=%b required 0 1", jump_drops, jumping);
    end
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1B, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b0 || ducking !== 1'b0) begin
      errors++;
      $display("FAIL break_not_held: j=%b d=%b required 0 0", jumping, ducking);
    end
  endtask

  task automatic test_parity;
    int e0;
    e0 = err_pulses;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b1, 1'b0);
    checks++;
    if (err_pulses !== e0 + 1 || ducking !== 1'b0) begin
      errors++;
      $display("FAIL parity_err: pulses=%0d ducking=%b required %0d 0", err_pulses, ducking, e0 + 1);
    end
    // ext must have been dropped by the bad frame, so plain 0x72 is unmapped
    send_frame(8'h72, 1'b0, 1'b0);
    checks++;
    if (ducking !== 1'b0) begin
      errors++;
      $display("FAIL ext_cleared_on_err: ducking=%b required 0", ducking);
    end
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b0, 1'b0);
    checks++;
    if (ducking !== 1'b1 || jumping !== 1'b0) begin
      errors++;
      $display("FAIL down_make: d=%b j=%b required 1 0", ducking, jumping);
    end
    send_frame(8'hAA, 1'b0, 1'b0);
    checks++;
    if (ducking !== 1'b0) begin
      errors++;
      $display("FAIL bat_clear: ducking=%b required 0", ducking);
    end
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL parity_single_pulse: pulses=%0d required %0d", err_pulses, e0 + 1);
    end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_pulses;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    idle(TO - 100);
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL timeout_early: pulses=%0d required %0d", err_pulses, e0);
    end
    idle(300);
    checks++;
    if (err_pulses !== e0 + 1) begin
      errors++;
      $display("FAIL timeout_pulse: pulses=%0d required %0d", err_pulses, e0 + 1);
    end
    send_frame(8'h1B, 1'b0, 1'b0);
    checks++;
    if (ducking !== 1'b1) begin
      errors++;
      $display("FAIL after_timeout_s: ducking=%b required 1", ducking);
    end
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1B, 1'b0, 1'b0);
    checks++;
    if (ducking !== 1'b0) begin
      errors++;
      $display("FAIL s_break: ducking=%b required 0", ducking);
    end
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_pulses;
    @(negedge clk);
    ps2_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(20);
      ps2_clk = 1'b0;
      idle(2);
      ps2_clk = 1'b1;
    end
    idle(20);
    ps2_data = 1'b1;
    // a glitch taken as a start bit would leave the receiver to time out
    idle(TO + 100);
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL glitch_no_sample: pulses=%0d required %0d", err_pulses, e0);
    end
    send_frame(8'h29, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b1 || err_pulses !== e0) begin
      errors++;
      $display("FAIL glitch_then_frame: j=%b pulses=%0d required 1 %0d", jumping, err_pulses, e0);
    end
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b0) begin
      errors++;
      $display("FAIL glitch_break: jumping=%b required 0", jumping);
    end
  endtask

  task automatic test_reset_midframe;
    int e0;
    send_frame(8'h1B, 1'b0, 1'b0);
    send_frame(8'h29, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b1 || ducking !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_keys: j=%b d=%b required 1 1", jumping, ducking);
    end
    e0 = err_pulses;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    checks++;
    if (jumping !== 1'b0 || ducking !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: j=%b d=%b e=%b required 0 0 0", jumping, ducking, frame_err);
    end
    rst = 1'b0;
    idle(TO + 100);
    checks++;
    if (err_pulses !== e0) begin
      errors++;
      $display("FAIL midframe_no_err: pulses=%0d required %0d", err_pulses, e0);
    end
    send_frame(8'h29, 1'b0, 1'b0);
    checks++;
    if (jumping !== 1'b1 || ducking !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_frame: j=%b d=%b required 1 0", jumping, ducking);
    end
  endtask

  initial begin
    test_reset;
    test_jump_basic;
    test_multi_jump;
    test_typematic;
    test_parity;
    test_timeout;
    test_glitch;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
